// File: rtl/serial_add_defs.sv
// Shared constants for the bit-serial adder controller: default width and
// the 2-bit state encoding.
package serial_add_defs;
  localparam int         SA_WIDTH_DEF = 8;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_DONE      = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;
endpackage

// File: rtl/full_adder.sv
// 1-bit full adder shared by the serial and ripple adder datapaths.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder stepped LSB first over WIDTH
// cycles, fronted by a start/done handshake.
module serial_add_ctrl
  import serial_add_defs::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             carry
);
  localparam int CNT_W = $clog2(WIDTH);

  state_t           st, st_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_nxt;
  logic             c_reg;
  logic [CNT_W-1:0] count;
  logic             fa_s, fa_co;
  logic             last;

  full_adder FA0 (
    .a (a_sh[0]),
    .b (b_sh[0]),
    .ci(c_reg),
    .s (fa_s),
    .co(fa_co)
  );

  assign s_nxt = {fa_s, s_sh[WIDTH-1:1]};
  assign last  = (count == CNT_W'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (reset) st <= S_IDLE;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    busy   = 1'b0;
    done   = 1'b0;
    case (st)
      S_IDLE: if (start) st_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last) st_nxt = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        st_nxt = S_IDLE;
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  // Result registers load on the final RUN edge so z/carry are already
  // valid during the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      c_reg <= 1'b0;
      count <= '0;
      z     <= '0;
      carry <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          count <= '0;
          if (start) begin
            a_sh  <= x;
            b_sh  <= y;
            s_sh  <= '0;
            c_reg <= 1'b0;
          end
        end
        S_RUN: begin
          s_sh  <= s_nxt;
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          c_reg <= fa_co;
          if (last) begin
            z     <= s_nxt;
            carry <= fa_co;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench: fixed vector table, random adds against an
// arithmetic model, abort-by-reset and a WIDTH=2 exhaustive sweep.
module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       start8, start2;
  logic [7:0] x8, y8, z8;
  logic [1:0] x2, y2, z2;
  logic       busy8, done8, carry8, busy2, done2, carry2;

  int         tests = 0;
  int         fails = 0;
  logic [8:0] last8, last2;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .x(x8), .y(y8),
    .busy(busy8), .done(done8), .z(z8), .carry(carry8)
  );

  serial_add_ctrl #(.WIDTH(2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .x(x2), .y(y2),
    .busy(busy2), .done(done2), .z(z2), .carry(carry2)
  );

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    int         mode;   // 0 plain, 1 start pulses while busy, 2 scramble x/y
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[6];

  function automatic int ref_sum(int w, int a, int b);
    int m = 1 << w;
    return ((a % m) + (b % m)) % (2 * m);
  endfunction

  function automatic logic [8:0] zc(bit w2);
    return w2 ? {6'd0, carry2, z2} : {carry8, z8};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(bit w2, logic s, logic [7:0] a, logic [7:0] b);
    if (w2) begin
      start2 = s; x2 = a[1:0]; y2 = b[1:0];
    end else begin
      start8 = s; x8 = a; y8 = b;
    end
  endtask

  task automatic op(bit w2, logic [7:0] xa, logic [7:0] ya, int mode, logic [8:0] exp);
    int  n, nbusy, lat;
    bit  seen, hold_ok;
    logic [8:0] prev;
    lat  = w2 ? 3 : 9;
    prev = w2 ? last2 : last8;
    @(negedge clk);
    chk("idle_busy", w2 ? busy2 : busy8, 0);
    chk("idle_done", w2 ? done2 : done8, 0);
    drive(w2, 1'b1, xa, ya);
    @(negedge clk);
    drive(w2, 1'b0, xa, ya);
    n = 1; nbusy = 0; seen = 0; hold_ok = 1;
    while (n < 60) begin
      if (w2 ? busy2 : busy8) nbusy++;
      if (w2 ? done2 : done8) begin
        seen = 1;
        break;
      end
      if (zc(w2) !== prev) hold_ok = 0;
      if (mode == 1) drive(w2, n == 3, 8'hFF, 8'hFF);
      if (mode == 2) drive(w2, 1'b0, 8'($urandom), 8'($urandom));
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(seen), 1);
    chk("latency", n, lat);
    chk("busy_cycles", nbusy, lat);
    chk("sum", zc(w2), exp);
    chk("z_hold", 32'(hold_ok), 1);
    // a start during the DONE cycle must be ignored
    if (mode == 1) drive(w2, 1'b1, 8'hFF, 8'hFF);
    if (w2) last2 = exp; else last8 = exp;
  endtask

  initial begin
    int nd;
    logic [7:0] a, b;
    tbl[0] = '{8'h5A, 8'h3C, 0, 9'h096};
    tbl[1] = '{8'hFF, 8'h01, 0, 9'h100};
    tbl[2] = '{8'hFF, 8'hFF, 0, 9'h1FE};
    tbl[3] = '{8'h10, 8'h20, 1, 9'h030};
    tbl[4] = '{8'h01, 8'h01, 0, 9'h002};
    tbl[5] = '{8'h77, 8'h19, 2, 9'h090};

    reset = 1'b1;
    drive(0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 8'h00, 8'h00);
    last8 = '0;
    last2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_zc8", zc(0), 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_zc2", zc(1), 0);

    foreach (tbl[i]) op(0, tbl[i].x, tbl[i].y, tbl[i].mode, tbl[i].exp);

    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      op(0, a, b, int'($urandom_range(0, 2)), 9'(ref_sum(8, a, b)));
    end
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 8'h00);

    // reset in the middle of a RUN aborts without a done pulse
    @(negedge clk);
    drive(0, 1'b1, 8'hAA, 8'h55);
    @(negedge clk);
    drive(0, 1'b0, 8'hAA, 8'h55);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_zc", zc(0), 0);
    last8 = '0;
    last2 = '0;
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8 || busy8) nd++;
    end
    chk("abort_quiet", nd, 0);
    op(0, 8'h0F, 8'h01, 0, 9'h010);

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        op(1, 8'(i), 8'(j), 0, 9'(ref_sum(2, i, j)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
